// File: rtl/lsu_unit.sv
// Load/store unit between the execute-stage ALU and a synchronous byte-enabled
// data memory (one-cycle read latency); returns extended load data to writeback.
module lsu_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [4:0]            rd_in,
    output logic                  dm_en,
    output logic [3:0]            dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [4:0]            rsp_rd,
    output logic                  misaligned
);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP, S_FAULT} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e                state_q, state_d;
    size_e                 size_q, size_d;
    logic [1:0]            lane_q, lane_d;
    logic                  sext_q, sext_d;
    logic                  load_q, load_d;
    logic [4:0]            rd_q, rd_d;
    logic                  req_ready_q, req_ready_d;
    logic                  dm_en_q, dm_en_d;
    logic [3:0]            dm_we_q, dm_we_d;
    logic [ADDR_WIDTH-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_WIDTH-1:0] dm_wdata_q, dm_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic [4:0]            rsp_rd_q, rsp_rd_d;
    logic                  misaligned_q, misaligned_d;

    size_e                 req_size;
    logic                  req_mis;
    logic [3:0]            req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] rd_ext;

    // Upper address bits fall outside the memory; the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALUResult[DATA_WIDTH-1:ADDR_WIDTH+2];

    // BU/HU encodings only exist for loads; for stores they decode as word.
    always_comb begin
        case (funct3)
            3'b000:  req_size = SZ_B;
            3'b001:  req_size = SZ_H;
            3'b100:  req_size = mem_read ? SZ_B : SZ_W;
            3'b101:  req_size = mem_read ? SZ_H : SZ_W;
            default: req_size = SZ_W;
        endcase
        req_mis = ((req_size == SZ_H) && ALUResult[0]) ||
                  ((req_size == SZ_W) && (ALUResult[1:0] != 2'b00));
        case (req_size)
            SZ_B: begin
                req_we    = 4'b0001 << ALUResult[1:0];
                req_wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                req_we    = ALUResult[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{store_data[15:0]}};
            end
            default: begin
                req_we    = 4'b1111;
                req_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        rd_byte = dm_rdata[8*lane_q +: 8];
        rd_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (size_q)
            SZ_B:    rd_ext = {{(DATA_WIDTH-8){sext_q & rd_byte[7]}}, rd_byte};
            SZ_H:    rd_ext = {{(DATA_WIDTH-16){sext_q & rd_half[15]}}, rd_half};
            default: rd_ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        lane_d       = lane_q;
        sext_d       = sext_q;
        load_d       = load_q;
        rd_d         = rd_q;
        req_ready_d  = 1'b0;
        dm_en_d      = 1'b0;
        dm_we_d      = '0;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        rsp_valid_d  = 1'b0;
        load_data_d  = load_data_q;
        rsp_rd_d     = rsp_rd_q;
        misaligned_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && (mem_read || mem_write)) begin
                    req_ready_d = 1'b0;
                    size_d      = req_size;
                    lane_d      = ALUResult[1:0];
                    sext_d      = ~funct3[2];
                    load_d      = mem_read;
                    rd_d        = rd_in;
                    if (req_mis) begin
                        state_d      = S_FAULT;
                        rsp_valid_d  = 1'b1;
                        misaligned_d = 1'b1;
                        load_data_d  = '0;
                        rsp_rd_d     = '0;
                    end else begin
                        state_d    = S_ACCESS;
                        dm_en_d    = 1'b1;
                        dm_we_d    = mem_read ? 4'b0000 : req_we;
                        dm_addr_d  = ALUResult[ADDR_WIDTH+1:2];
                        dm_wdata_d = req_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (load_q) begin
                    state_d = S_WAIT;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    load_data_d = '0;
                    rsp_rd_d    = '0;
                end
            end
            S_WAIT: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                load_data_d = rd_ext;
                rsp_rd_d    = rd_q;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            size_q       <= SZ_B;
            lane_q       <= '0;
            sext_q       <= 1'b0;
            load_q       <= 1'b0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            dm_en_q      <= 1'b0;
            dm_we_q      <= '0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            rsp_valid_q  <= 1'b0;
            load_data_q  <= '0;
            rsp_rd_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            sext_q       <= sext_d;
            load_q       <= load_d;
            rd_q         <= rd_d;
            req_ready_q  <= req_ready_d;
            dm_en_q      <= dm_en_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            load_data_q  <= load_data_d;
            rsp_rd_q     <= rsp_rd_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign dm_en      = dm_en_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign load_data  = load_data_q;
    assign rsp_rd     = rsp_rd_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized bench for lsu_unit: byte-addressed reference memory model plus a
// simple synchronous memory attached to the DUT's memory port.
module tb_lsu_unit;

    typedef struct packed {
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] data;
        bit [4:0]  rdx;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, store_data;
    logic [4:0]  rd_in;
    logic        dm_en;
    logic [3:0]  dm_we;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        rsp_valid;
    logic [31:0] load_data;
    logic [4:0]  rsp_rd;
    logic        misaligned;

    int vectors = 0;
    int miscompares = 0;
    logic        fill = 1'b0;
    logic [7:0]  ref_mem [2048];
    logic [31:0] mem [512];
    logic [3:0]  obs_we;
    logic [8:0]  obs_addr;
    logic [31:0] obs_wdata, obs_data;
    logic [4:0]  obs_rd;
    logic        obs_mis;

    always #5 clk = ~clk;

    lsu_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .ALUResult(ALUResult), .store_data(store_data), .rd_in(rd_in),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .rsp_valid(rsp_valid), .load_data(load_data),
        .rsp_rd(rsp_rd), .misaligned(misaligned)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
        end else if (dm_en) begin
            dm_rdata <= mem[dm_addr];
            for (int i = 0; i < 4; i++)
                if (dm_we[i]) mem[dm_addr][8*i +: 8] <= dm_wdata[8*i +: 8];
        end
    end

    function automatic int m_size(req_t r);
        if (r.rd) return (r.f3 == 3'd0 || r.f3 == 3'd4) ? 1 : (r.f3 == 3'd1 || r.f3 == 3'd5) ? 2 : 4;
        return (r.f3 == 3'd0) ? 1 : (r.f3 == 3'd1) ? 2 : 4;
    endfunction

    task automatic drive(req_t r);
        req_valid = 1'b1; mem_read = r.rd; mem_write = r.wr; funct3 = r.f3;
        ALUResult = r.addr; store_data = r.data; rd_in = r.rdx;
    endtask

    // Issue one request, check its whole timeline; when hold is set, nxt is
    // presented immediately after the accept edge with req_valid kept high.
    task automatic run_req(string tag, req_t r, bit hold, req_t nxt);
        int sz, lat, ba, waitc;
        bit fault, exp_en, exp_rv, exp_rdy;
        logic [31:0] exp_data, exp_wdata;
        logic [3:0]  exp_we;
        logic [4:0]  exp_rd;
        logic [8:0]  exp_addr;
        sz = m_size(r);
        fault = (r.addr % sz) != 0;
        ba = int'(r.addr % 2048);
        lat = fault ? 1 : (r.rd ? 3 : 2);
        exp_addr = 9'((r.addr >> 2) % 512);
        exp_data = '0; exp_we = '0; exp_wdata = '0;
        exp_rd = (r.rd && !fault) ? r.rdx : 5'd0;
        if (r.rd && !fault) begin
            for (int i = sz - 1; i >= 0; i--) exp_data = (exp_data << 8) | 32'(ref_mem[ba + i]);
            if (sz < 4 && r.f3 < 3'd4 && exp_data[8*sz-1]) exp_data = exp_data | ~((32'd1 << (8*sz)) - 1);
        end
        for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = r.data[8*(i % sz) +: 8];
        for (int i = 0; i < sz; i++) exp_we[(ba % 4) + i] = 1'b1;
        if (r.rd) exp_we = '0;
        drive(r);
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept_timeout: req_ready=%b, expected 1", tag, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (hold) drive(nxt);
        else req_valid = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            exp_en = (k == 1) && !fault;
            exp_rv = (k == lat);
            exp_rdy = (k == lat + 1);
            vectors++;
            if (dm_en !== exp_en || rsp_valid !== exp_rv || req_ready !== exp_rdy ||
                (!exp_en && dm_we !== 4'b0000)) begin
                miscompares++;
                $display("FAIL %s timing k=%0d: dm_en=%b dm_we=%b rsp_valid=%b req_ready=%b, expected %b %b %b %b",
                         tag, k, dm_en, dm_we, rsp_valid, req_ready, exp_en, exp_en ? exp_we : 4'b0, exp_rv, exp_rdy);
            end
            if (k == 1 && exp_en) begin
                obs_we = dm_we; obs_addr = dm_addr; obs_wdata = dm_wdata;
                vectors++;
                if (dm_we !== exp_we || dm_addr !== exp_addr || (!r.rd && dm_wdata !== exp_wdata)) begin
                    miscompares++;
                    $display("FAIL %s mem_port: we=%b addr=%0d wdata=%h, expected %b %0d %h",
                             tag, dm_we, dm_addr, dm_wdata, exp_we, exp_addr, exp_wdata);
                end
            end
            if (k == lat) begin
                obs_data = load_data; obs_rd = rsp_rd; obs_mis = misaligned;
                vectors++;
                if (load_data !== exp_data || rsp_rd !== exp_rd || misaligned !== fault) begin
                    miscompares++;
                    $display("FAIL %s response: data=%h rd=%0d mis=%b, expected %h %0d %b",
                             tag, load_data, rsp_rd, misaligned, exp_data, exp_rd, fault);
                end
            end
            if (k == lat + 1) begin
                vectors++;
                if (load_data !== exp_data || rsp_rd !== exp_rd) begin
                    miscompares++;
                    $display("FAIL %s hold: data=%h rd=%0d, expected %h %0d", tag, load_data, rsp_rd, exp_data, exp_rd);
                end
            end
        end
        if (r.wr && !r.rd && !fault)
            for (int i = 0; i < sz; i++) ref_mem[ba + i] = r.data[8*i +: 8];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fill = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = '0; ALUResult = '0; store_data = '0; rd_in = '0;
        for (int w = 0; w < 512; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8*b);
        @(negedge clk);
        @(negedge clk);
        fill = 1'b0;
        vectors++;
        if ({req_ready, dm_en, dm_we, dm_addr, dm_wdata, rsp_valid, load_data, rsp_rd, misaligned} !== {1'b1, 85'd0}) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b en=%b we=%b addr=%0d wdata=%h rv=%b data=%h rd=%0d mis=%b, expected ready=1 rest 0",
                     req_ready, dm_en, dm_we, dm_addr, dm_wdata, rsp_valid, load_data, rsp_rd, misaligned);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b, expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_ignore();
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 1'b1 || dm_en !== 1'b0 || rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL ignore_no_op: ready=%b en=%b rv=%b, expected 1 0 0", req_ready, dm_en, rsp_valid);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_word();
        run_req("sw", '{rd:0, wr:1, f3:3'd2, addr:32'h10, data:32'hDEADBEEF, rdx:5'd3}, 1'b0, '0);
        vectors++;
        if (obs_we !== 4'b1111 || obs_addr !== 9'd4) begin
            miscompares++;
            $display("FAIL sw_port: we=%b addr=%0d, expected 1111 4", obs_we, obs_addr);
        end
        run_req("lw", '{rd:1, wr:0, f3:3'd2, addr:32'h10, data:32'h0, rdx:5'd5}, 1'b0, '0);
        vectors++;
        if (obs_data !== 32'hDEADBEEF || obs_rd !== 5'd5) begin
            miscompares++;
            $display("FAIL lw_result: data=%h rd=%0d, expected deadbeef 5", obs_data, obs_rd);
        end
    endtask

    task automatic test_byte_half();
        run_req("sb", '{rd:0, wr:1, f3:3'd0, addr:32'h13, data:32'h000000A5, rdx:5'd0}, 1'b0, '0);
        vectors++;
        if (obs_we !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL sb_port: we=%b wdata=%h, expected 1000 a5a5a5a5", obs_we, obs_wdata);
        end
        run_req("lb", '{rd:1, wr:0, f3:3'd0, addr:32'h13, data:32'h0, rdx:5'd6}, 1'b0, '0);
        vectors++;
        if (obs_data !== 32'hFFFFFFA5) begin
            miscompares++;
            $display("FAIL lb_sext: data=%h, expected ffffffa5", obs_data);
        end
        run_req("lbu", '{rd:1, wr:0, f3:3'd4, addr:32'h13, data:32'h0, rdx:5'd7}, 1'b0, '0);
        vectors++;
        if (obs_data !== 32'h000000A5) begin
            miscompares++;
            $display("FAIL lbu_zext: data=%h, expected 000000a5", obs_data);
        end
        run_req("sh", '{rd:0, wr:1, f3:3'd1, addr:32'h22, data:32'h00008001, rdx:5'd0}, 1'b0, '0);
        vectors++;
        if (obs_we !== 4'b1100 || obs_wdata !== 32'h80018001) begin
            miscompares++;
            $display("FAIL sh_port: we=%b wdata=%h, expected 1100 80018001", obs_we, obs_wdata);
        end
        run_req("lh", '{rd:1, wr:0, f3:3'd1, addr:32'h22, data:32'h0, rdx:5'd8}, 1'b0, '0);
        run_req("lhu", '{rd:1, wr:0, f3:3'd5, addr:32'h22, data:32'h0, rdx:5'd9}, 1'b0, '0);
        vectors++;
        if (obs_data !== 32'h00008001) begin
            miscompares++;
            $display("FAIL lhu_zext: data=%h, expected 00008001", obs_data);
        end
    endtask

    task automatic test_misaligned();
        run_req("lw_mis", '{rd:1, wr:0, f3:3'd2, addr:32'h06, data:32'h0, rdx:5'd7}, 1'b0, '0);
        run_req("sh_mis", '{rd:0, wr:1, f3:3'd1, addr:32'h05, data:32'h1234, rdx:5'd0}, 1'b0, '0);
        vectors++;
        if (obs_mis !== 1'b1 || obs_data !== 32'h0 || obs_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL sh_mis_flags: mis=%b data=%h rd=%0d, expected 1 0 0", obs_mis, obs_data, obs_rd);
        end
    endtask

    task automatic test_reset_abort();
        drive('{rd:0, wr:1, f3:3'd2, addr:32'h40, data:32'h12345678, rdx:5'd0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        vectors++;
        if (dm_en !== 1'b1 || dm_we !== 4'b1111) begin
            miscompares++;
            $display("FAIL abort_access: dm_en=%b dm_we=%b, expected 1 1111", dm_en, dm_we);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (dm_en !== 1'b0 || dm_we !== 4'b0000 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_async: en=%b we=%b ready=%b rv=%b, expected 0 0000 1 0", dm_en, dm_we, req_ready, rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dm_en !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet: rv=%b ready=%b en=%b, expected 0 1 0", rsp_valid, req_ready, dm_en);
            end
        end
        run_req("lw_after_abort", '{rd:1, wr:0, f3:3'd2, addr:32'h40, data:32'h0, rdx:5'd9}, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        req_t q [12];
        for (int i = 0; i < 12; i++) begin
            q[i].rd = (i % 2) == 0;
            q[i].wr = !q[i].rd;
            q[i].f3 = 3'd2;
            q[i].addr = 32'($urandom_range(0, 7)) * 4;
            q[i].data = $urandom;
            q[i].rdx = 5'($urandom_range(1, 31));
        end
        for (int i = 0; i < 12; i++) run_req("b2b", q[i], i < 11, q[(i + 1) % 12]);
    endtask

    task automatic test_random();
        req_t r;
        int mode;
        for (int n = 0; n < 200; n++) begin
            r.rd = 1'($urandom_range(0, 1));
            r.wr = r.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            r.f3 = 3'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: r.addr = 32'($urandom_range(0, 63));
                1: r.addr = 32'($urandom_range(2040, 2047));
                2: r.addr = $urandom;
                default: r.addr = ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 63));
            endcase
            r.data = $urandom;
            r.rdx = 5'($urandom_range(0, 31));
            run_req("rand", r, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_word();
        test_byte_half();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit sitting directly downstream of the execute-stage ALU: consumes ALUResult as the effective byte address for loads/stores.
- Drives the synchronous data memory (byte write enables, 1-cycle read latency).
- Returns sign/zero-extended load data plus destination register to writeback through a valid/ready request and a one-cycle response pulse.

Parameters:
DATA_WIDTH, 32, operand/data width (fixed 32 for RV32).
ADDR_WIDTH, 9, data memory word-address width; memory holds 2^ADDR_WIDTH words.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request (high only in IDLE).
mem_read  input  1  request is a load.
mem_write  input  1  request is a store.
funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
ALUResult  input  DATA_WIDTH  effective byte address from ALU.
store_data  input  DATA_WIDTH  rs2 value for stores.
rd_in  input  5  load destination register.
dm_en  output  1  memory access strobe.
dm_we  output  4  per-byte write enables (bit i = byte lane i).
dm_addr  output  ADDR_WIDTH  word address = latched ALUResult[ADDR_WIDTH+1:2].
dm_wdata  output  DATA_WIDTH  lane-aligned store data.
dm_rdata  input  DATA_WIDTH  read data, valid the cycle after dm_en.
rsp_valid  output  1  one-cycle completion pulse.
load_data  output  DATA_WIDTH  extended load result (0 for stores/faults).
rsp_rd  output  5  destination register (0 for stores/faults).
misaligned  output  1  fault flag, qualified by rsp_valid.

Behaviour:
- Reset: asynchronous on rst_n low. State returns to IDLE. All outputs are 0 except req_ready=1. Deassertion is clean on the next edge. A reset mid-access aborts it: no write lands after the reset edge, and no rsp_valid is produced.
- FSM states: IDLE, ACCESS, WAIT, RESP, FAULT.
- IDLE: accept when req_valid && (mem_read || mem_write).
  - Latch address, funct3, store_data, rd_in, and op. Both bits set: load wins.
  - Alignment check: H/HU require addr[0]=0; W requires addr[1:0]=0. Misaligned goes to FAULT; otherwise goes to ACCESS.
  - req_valid with neither bit set is ignored (no state change).
- ACCESS: dm_en=1 for exactly one cycle.
  - Store: dm_we = 0001<<a[1:0] (B), 0011<<{a[1],0} (H), 1111 (W). Next state RESP.
  - Load: dm_we=0000. Next state WAIT.
- WAIT: sample dm_rdata at end of cycle.
  - Select lane by a[1:0].
  - Extension: sign-extend for B/H; zero-extend for BU/HU; W passes through.
  - Register result into load_data. Next state RESP.
- RESP: rsp_valid=1 for one cycle, misaligned=0, rsp_rd=rd (0 for store). Next state IDLE.
- FAULT: rsp_valid=1, misaligned=1, load_data=0, rsp_rd=0. No dm_en in any cycle of the request. Next state IDLE.
- Store lane data: SB replicates byte into all 4 lanes; SH replicates halfword into both halves; SW passes through.
- Undefined funct3 (011, 110, 111, or any ≥011 on stores) is treated as word.
- Address bits above ADDR_WIDTH+1 are ignored; the address wraps modulo memory size.
- load_data and rsp_rd hold their values until the next response. rsp_valid is never asserted for two consecutive cycles.
- Latency (accept edge = T):
  - Store: write at T+1, rsp_valid at T+2.
  - Load: dm_en at T+1, rsp_valid at T+3.
  - Fault: rsp_valid at T+1.
  - Throughput is one request per 3/4/2 cycles respectively. Back-to-back accept is legal in the cycle after RESP/FAULT.
- dm_en and dm_we are 0 in every state except ACCESS.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF; then LW 0x10, rd=5 -> dm_we=1111 and dm_addr=4 at T+1; load_data=0xDEADBEEF, rsp_rd=5, rsp_valid exactly at T+3.
2. SB addr 0x13, data 0x000000A5; then LB 0x13 and LBU 0x13 -> dm_we=1000, dm_wdata=0xA5A5A5A5; LB=0xFFFFFFA5, LBU=0x000000A5.
3. SH addr 0x22, data 0x8001; then LH / LHU 0x22 -> dm_we=1100; LH=0xFFFF8001, LHU=0x00008001.
4. LW addr 0x06, then SH addr 0x05 -> each gives rsp_valid+misaligned at T+1, load_data=0, rsp_rd=0, dm_en never asserted.
5. SW issued, rst_n pulled low during ACCESS -> dm_we drops to 0 immediately, no rsp_valid, req_ready=1 after release; subsequent LW completes normally.
6. req_valid held high continuously with alternating LW/SW -> req_ready low except in IDLE, no request lost or duplicated, rsp_valid single-cycle pulses with correct data per request.
